// File: rtl/sobel_magnitude.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sobel_magnitude
//
// Purpose: turns a stream of Sobel gradient pairs (gx, gy) into an 8-bit
// (WIDTH_P) edge magnitude |gx| + |gy| and an edge flag.
// - The magnitude saturates at the top of the WIDTH_P range.
// - The block tracks the pixel position within the frame. Pixels whose 3x3
//   window is not fully populated (first two columns or first two rows) come
//   out as zero magnitude with no edge.
// - It flags the last pixel of each frame.
//
// Two-stage valid/ready pipeline with one global enable.
//   Stage 1: absolute values plus position flags.
//   Stage 2: sum, saturate, border masking and threshold compare.
//
// Ports:
//   clk_i    - clock
//   rstn_i   - asynchronous active-low reset
//   valid_i  - input beat valid
//   ready_o  - block can accept an input beat
//   gx_i     - signed horizontal gradient, 2*WIDTH_P bits
//   gy_i     - signed vertical gradient, 2*WIDTH_P bits
//   thresh_i - unsigned edge threshold (quasi-static)
//   valid_o  - output beat valid
//   ready_i  - downstream accepts the output beat
//   mag_o    - saturated gradient magnitude, 0 on border pixels
//   edge_o   - mag_o >= thresh_i, 0 on border pixels
//   last_o   - beat is the final pixel of the frame
// -----------------------------------------------------------------------------
module sobel_magnitude #(
    parameter int unsigned WIDTH_P  = 8,
    parameter int unsigned DEPTH_P  = 16,
    parameter int unsigned HEIGHT_P = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*WIDTH_P-1:0]   gx_i,
    input  logic [2*WIDTH_P-1:0]   gy_i,
    input  logic [WIDTH_P-1:0]     thresh_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_P-1:0]     mag_o,
    output logic                   edge_o,
    output logic                   last_o
);

    localparam int unsigned GW = 2 * WIDTH_P;
    localparam int unsigned CW = (DEPTH_P > 2) ? $clog2(DEPTH_P) : 2;
    localparam int unsigned RW = (HEIGHT_P > 2) ? $clog2(HEIGHT_P) : 2;

    localparam logic [CW-1:0] ColLast = CW'(DEPTH_P - 1);
    localparam logic [RW-1:0] RowLast = RW'(HEIGHT_P - 1);

    // Absolute value of a two's complement gradient. The most negative code
    // negates to itself, so it is clamped to the largest positive value.
    function automatic logic [GW-1:0] f_abs_clamp(input logic [GW-1:0] v);
        logic [GW-1:0] neg;
        neg = ~v + GW'(1);
        if (!v[GW-1]) begin
            return v;
        end else if (neg[GW-1]) begin
            return {1'b0, {(GW-1){1'b1}}};
        end else begin
            return neg;
        end
    endfunction

    // Pipeline control
    logic          w_en;
    logic          w_accept;

    // Frame position
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_border;
    logic          w_last;

    // Stage 1
    logic          r_s1_valid;
    logic [GW-1:0] r_s1_abs_gx;
    logic [GW-1:0] r_s1_abs_gy;
    logic          r_s1_border;
    logic          r_s1_last;

    // Stage 2 compute
    logic [GW:0]        w_sum;
    logic [WIDTH_P-1:0] w_mag_sat;
    logic [WIDTH_P-1:0] w_mag;
    logic               w_edge;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [WIDTH_P-1:0] r_mag;
    logic               r_edge;
    logic               r_last;

    // The whole pipeline advances together. A full output stage that is
    // not being taken stalls everything behind it.
    assign w_en     = ~r_s2_valid | ready_i;
    assign w_accept = valid_i & w_en;
    assign ready_o  = w_en;

    assign w_col_last = (r_col == ColLast);
    assign w_row_last = (r_row == RowLast);
    assign w_border   = (r_col < CW'(2)) | (r_row < RW'(2));
    assign w_last     = w_col_last & w_row_last;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Stage 1: absolute values and position flags.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_abs_gx <= '0;
            r_s1_abs_gy <= '0;
            r_s1_border <= 1'b0;
            r_s1_last   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_abs_gx <= f_abs_clamp(gx_i);
                r_s1_abs_gy <= f_abs_clamp(gy_i);
                r_s1_border <= w_border;
                r_s1_last   <= w_last;
            end
        end
    end

    // Stage 2: one extra bit so the sum of two clamped magnitudes cannot wrap.
    always_comb begin
        w_sum     = {1'b0, r_s1_abs_gx} + {1'b0, r_s1_abs_gy};
        w_mag_sat = (|w_sum[GW:WIDTH_P]) ? {WIDTH_P{1'b1}} : w_sum[WIDTH_P-1:0];
        w_mag     = r_s1_border ? '0 : w_mag_sat;
        w_edge    = ~r_s1_border & (w_mag_sat >= thresh_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_s2_valid <= 1'b0;
            r_mag      <= '0;
            r_edge     <= 1'b0;
            r_last     <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mag  <= w_mag;
                r_edge <= w_edge;
                r_last <= r_s1_last;
            end
        end
    end

    assign valid_o = r_s2_valid;
    assign mag_o   = r_mag;
    assign edge_o  = r_edge;
    assign last_o  = r_last;

endmodule

// File: tb/tb_sobel_magnitude.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sobel_magnitude
//
// Directed bench for sobel_magnitude with the default 8-bit, 16x16 frame.
// - Inputs are driven #1 after each rising edge.
// - Outputs are sampled at the same point, so each sample reflects the
//   state that edge produced.
// - The bench keeps its own frame position (pos) and uses it to predict
//   which beats are border beats and which beat is last.
// -----------------------------------------------------------------------------
module tb_sobel_magnitude;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int H  = 16;
    localparam int GW = 2 * W;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          valid_i;
    logic          ready_o;
    logic [GW-1:0] gx_i;
    logic [GW-1:0] gy_i;
    logic [W-1:0]  thresh_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  mag_o;
    logic          edge_o;
    logic          last_o;

    int n_pass  = 0;
    int n_total = 0;
    int pos     = 0;

    sobel_magnitude #(
        .WIDTH_P  (W),
        .DEPTH_P  (D),
        .HEIGHT_P (H)
    ) u_dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .gx_i     (gx_i),
        .gy_i     (gy_i),
        .thresh_i (thresh_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .mag_o    (mag_o),
        .edge_o   (edge_o),
        .last_o   (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input int x, input int y);
        valid_i = v;
        gx_i    = GW'(x);
        gy_i    = GW'(y);
    endtask

    function automatic bit is_border(input int p);
        return ((p % D) < 2) || ((p / D) < 2);
    endfunction

    // Feed zero beats until the next n beats sit on interior pixels of one
    // row, then let the pipeline drain.
    task automatic advance_to_interior(input int n);
        ready_i = 1'b1;
        while (((pos % D) < 2) || ((pos / D) < 2) || ((D - (pos % D)) < n)) begin
            drive(1'b1, 0, 0);
            tick();
            pos = (pos + 1) % (D * H);
        end
        drive(1'b0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 0, 0);
        ready_i  = 1'b0;
        thresh_i = '0;
        #2 rstn_i = 1'b0;
        #1;
        n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
        n_total++; if (mag_o !== 8'd0) $display("FAIL reset_mag: got %0d want 0", mag_o); else n_pass++;
        n_total++; if (edge_o !== 1'b0) $display("FAIL reset_edge: got %b want 0", edge_o); else n_pass++;
        n_total++; if (last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", last_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
        tick();
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL reset_hold_valid: got %b want 0", valid_o); else n_pass++;
        ready_i = 1'b1;
        rstn_i  = 1'b1;
        pos     = 0;
        tick();
    endtask

    // A full frame plus 40 beats of the next one. Border beats carry a large
    // gradient that must be masked; interior beats give 3 + 4 = 7.
    task automatic test_stream_frame();
        int  em[$];
        bit  ee[$];
        bit  el[$];
        int  n = D * H + 40;
        int  p;
        int  m;
        bit  b;
        bit  e;
        bit  l;
        thresh_i = 8'd5;
        ready_i  = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                p = pos;
                b = is_border(p);
                if (b) drive(1'b1, 500, 0);
                else   drive(1'b1, 3, -4);
                em.push_back(b ? 0 : 7);
                ee.push_back(!b);
                el.push_back(p == D * H - 1);
                pos = (pos + 1) % (D * H);
            end else begin
                drive(1'b0, 0, 0);
            end
            tick();
            if (i >= 1) begin
                m = em.pop_front();
                e = ee.pop_front();
                l = el.pop_front();
                n_total++; if (valid_o !== 1'b1) $display("FAIL stream_valid beat %0d: got %b want 1", i - 1, valid_o); else n_pass++;
                n_total++; if (mag_o !== 8'(m)) $display("FAIL stream_mag beat %0d: got %0d want %0d", i - 1, mag_o, m); else n_pass++;
                n_total++; if (edge_o !== e) $display("FAIL stream_edge beat %0d: got %b want %b", i - 1, edge_o, e); else n_pass++;
                n_total++; if (last_o !== l) $display("FAIL stream_last beat %0d: got %b want %b", i - 1, last_o, l); else n_pass++;
            end
        end
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL stream_drain_valid: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_saturation();
        int vx[5] = '{1020, -32768, 200, 200, -32768};
        int vy[5] = '{-1020, 0, 55, 54, -32768};
        int vm[5] = '{255, 255, 255, 254, 255};
        advance_to_interior(5);
        thresh_i = 8'd5;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                drive(1'b1, vx[i], vy[i]);
                pos = (pos + 1) % (D * H);
            end else begin
                drive(1'b0, 0, 0);
            end
            tick();
            if (i >= 1) begin
                n_total++; if (valid_o !== 1'b1) $display("FAIL sat_valid vec %0d: got %b want 1", i - 1, valid_o); else n_pass++;
                n_total++; if (mag_o !== 8'(vm[i - 1])) $display("FAIL sat_mag vec %0d: got %0d want %0d", i - 1, mag_o, vm[i - 1]); else n_pass++;
                n_total++; if (edge_o !== 1'b1) $display("FAIL sat_edge vec %0d: got %b want 1", i - 1, edge_o); else n_pass++;
            end
        end
    endtask

    task automatic test_threshold();
        int vx[4] = '{99, -50, 101, 0};
        int vy[4] = '{0, 50, 0, 0};
        int vm[4] = '{99, 100, 101, 0};
        bit ve[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        advance_to_interior(4);
        thresh_i = 8'd100;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                drive(1'b1, vx[i], vy[i]);
                pos = (pos + 1) % (D * H);
            end else begin
                drive(1'b0, 0, 0);
            end
            tick();
            if (i >= 1) begin
                n_total++; if (mag_o !== 8'(vm[i - 1])) $display("FAIL thr_mag vec %0d: got %0d want %0d", i - 1, mag_o, vm[i - 1]); else n_pass++;
                n_total++; if (edge_o !== ve[i - 1]) $display("FAIL thr_edge vec %0d: got %b want %b", i - 1, edge_o, ve[i - 1]); else n_pass++;
            end
        end
    endtask

    // Beat k carries gx = 10*(k+1), so every beat is identifiable at the
    // output. A stall of 5 cycles must freeze beat 0 and then release the
    // beats in order with nothing repeated or skipped.
    task automatic test_backpressure();
        advance_to_interior(6);
        thresh_i = 8'd25;
        ready_i  = 1'b1;
        drive(1'b1, 10, 0);
        tick();
        pos = (pos + 1) % (D * H);
        drive(1'b1, 20, 0);
        tick();
        pos = (pos + 1) % (D * H);
        n_total++; if (mag_o !== 8'd10) $display("FAIL bp_first_mag: got %0d want 10", mag_o); else n_pass++;
        ready_i = 1'b0;
        drive(1'b1, 30, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++; if (valid_o !== 1'b1) $display("FAIL bp_stall_valid cyc %0d: got %b want 1", c, valid_o); else n_pass++;
            n_total++; if (mag_o !== 8'd10) $display("FAIL bp_stall_mag cyc %0d: got %0d want 10", c, mag_o); else n_pass++;
            n_total++; if (edge_o !== 1'b0) $display("FAIL bp_stall_edge cyc %0d: got %b want 0", c, edge_o); else n_pass++;
            n_total++; if (ready_o !== 1'b0) $display("FAIL bp_stall_ready cyc %0d: got %b want 0", c, ready_o); else n_pass++;
        end
        ready_i = 1'b1;
        tick();
        pos = (pos + 1) % (D * H);
        n_total++; if (mag_o !== 8'd20) $display("FAIL bp_release_mag: got %0d want 20", mag_o); else n_pass++;
        for (int k = 3; k <= 5; k++) begin
            drive(1'b1, 10 * (k + 1), 0);
            tick();
            pos = (pos + 1) % (D * H);
            n_total++; if (mag_o !== 8'(10 * k)) $display("FAIL bp_order_mag k %0d: got %0d want %0d", k, mag_o, 10 * k); else n_pass++;
            n_total++; if (edge_o !== 1'b1) $display("FAIL bp_order_edge k %0d: got %b want 1", k, edge_o); else n_pass++;
        end
        drive(1'b0, 0, 0);
        tick();
        n_total++; if (mag_o !== 8'd60) $display("FAIL bp_tail_mag: got %0d want 60", mag_o); else n_pass++;
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int em[$];
        int n = 40;
        int m;
        bit b;
        advance_to_interior(2);
        thresh_i = 8'd5;
        drive(1'b1, 3, -4);
        tick();
        pos = (pos + 1) % (D * H);
        drive(1'b1, 3, -4);
        tick();
        pos = (pos + 1) % (D * H);
        n_total++; if (mag_o !== 8'd7) $display("FAIL rst_pre_mag: got %0d want 7", mag_o); else n_pass++;
        drive(1'b0, 0, 0);
        #2 rstn_i = 1'b0;
        #1;
        n_total++; if (valid_o !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", valid_o); else n_pass++;
        n_total++; if (mag_o !== 8'd0) $display("FAIL rst_async_mag: got %0d want 0", mag_o); else n_pass++;
        n_total++; if (edge_o !== 1'b0) $display("FAIL rst_async_edge: got %b want 0", edge_o); else n_pass++;
        n_total++; if (ready_o !== 1'b1) $display("FAIL rst_async_ready: got %b want 1", ready_o); else n_pass++;
        tick();
        rstn_i = 1'b1;
        pos    = 0;
        tick();
        tick();
        n_total++; if (valid_o !== 1'b0) $display("FAIL rst_discard_valid: got %b want 0", valid_o); else n_pass++;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                b = is_border(pos);
                if (b) drive(1'b1, 500, 0);
                else   drive(1'b1, 3, -4);
                em.push_back(b ? 0 : 7);
                pos = (pos + 1) % (D * H);
            end else begin
                drive(1'b0, 0, 0);
            end
            tick();
            if (i >= 1) begin
                m = em.pop_front();
                n_total++; if (mag_o !== 8'(m)) $display("FAIL rst_frame_mag beat %0d: got %0d want %0d", i - 1, mag_o, m); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream_frame();
        test_saturation();
        test_threshold();
        test_backpressure();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1 ms");
        $fatal(1);
    end

endmodule
